// File: rtl/ece551_pkg.sv
// Shared constants and types for the image-loading path.
// Sizes match the 28x28 binary input RAM.
package ece551_pkg;

    localparam int IMG_BITS  = 784;
    localparam int IN_ADDR_W = 10;

    typedef enum logic [1:0] {
        WAIT_BYTE,
        UNPACK,
        DONE
    } loader_state_t;

endpackage

// File: rtl/input_ram_loader.sv
// Unpacks received UART bytes LSB-first into the 1-bit-wide input RAM.
// Raises load_done once NUM_BITS bits have been written.
module input_ram_loader
    import ece551_pkg::*;
#(
    parameter int NUM_BITS   = IMG_BITS,
    parameter int ADDR_WIDTH = IN_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_rdy,
    output logic                  rx_clr_rdy,
    input  logic                  restart,
    output logic                  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  load_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_BITS - 1);

    loader_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            shreg_q, shreg_d;
    logic [2:0]            bitcnt_q, bitcnt_d;
    logic                  clr_q, clr_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        clr_d    = 1'b0;
        // restart wins over a pending byte; that byte is taken later
        if (restart) begin
            state_d  = WAIT_BYTE;
            addr_d   = '0;
            bitcnt_d = '0;
        end else begin
            unique case (state_q)
                WAIT_BYTE: begin
                    if (rx_rdy) begin
                        shreg_d  = rx_data;
                        bitcnt_d = '0;
                        clr_d    = 1'b1;
                        state_d  = UNPACK;
                    end
                end
                UNPACK: begin
                    shreg_d  = {1'b0, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (bitcnt_q == 3'd7) begin
                            state_d = WAIT_BYTE;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = WAIT_BYTE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_BYTE;
            addr_q   <= '0;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            clr_q    <= clr_d;
        end
    end

    assign ram_we     = (state_q == UNPACK);
    assign busy       = (state_q == UNPACK);
    assign ram_data   = shreg_q[0];
    assign ram_addr   = addr_q;
    assign load_done  = (state_q == DONE);
    assign rx_clr_rdy = clr_q;

endmodule

// File: tb/tb_input_ram_loader.sv
// Directed and random checks of input_ram_loader against a RAM model,
// a UART receiver model and an image-bit reference derived from the bytes.
module tb_input_ram_loader;

    logic clk = 1'b0;
    logic rst;
    logic restart;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main DUT (784 bits)
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rx_clr_rdy, ram_data, ram_we, busy, load_done;
    logic [9:0] ram_addr;

    input_ram_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_rdy(rx_rdy),
        .rx_clr_rdy(rx_clr_rdy), .restart(restart), .ram_data(ram_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .busy(busy),
        .load_done(load_done)
    );

    // short-image DUT (12 bits)
    logic [7:0] rx_data2 = 8'h00;
    logic       rx_rdy2 = 1'b0;
    logic       rx_clr_rdy2, ram_data2, ram_we2, busy2, load_done2;
    logic [9:0] ram_addr2;

    input_ram_loader #(.NUM_BITS(12), .ADDR_WIDTH(10)) u12 (
        .clk(clk), .rst(rst), .rx_data(rx_data2), .rx_rdy(rx_rdy2),
        .rx_clr_rdy(rx_clr_rdy2), .restart(restart), .ram_data(ram_data2),
        .ram_addr(ram_addr2), .ram_we(ram_we2), .busy(busy2),
        .load_done(load_done2)
    );

    // UART receiver models: rx_rdy stays high while a byte is queued
    logic [7:0] rxq[$];
    logic [7:0] rxq2[$];
    always @(negedge clk) begin
        if (rx_clr_rdy && rxq.size() > 0) void'(rxq.pop_front());
        rx_rdy  = (rxq.size() != 0);
        rx_data = rx_rdy ? rxq[0] : 8'h00;
        if (rx_clr_rdy2 && rxq2.size() > 0) void'(rxq2.pop_front());
        rx_rdy2  = (rxq2.size() != 0);
        rx_data2 = rx_rdy2 ? rxq2[0] : 8'h00;
    end

    // RAM models and activity counters
    logic ram [0:1023];
    logic ram2 [0:1023];
    logic img_init [0:1023];
    logic init_ram = 1'b0;
    int we_cnt = 0, clr_cnt = 0, we2_cnt = 0, clr2_cnt = 0;
    always @(posedge clk) begin
        if (init_ram) begin
            for (int i = 0; i < 1024; i++) begin
                ram[i]  <= img_init[i];
                ram2[i] <= 1'b0;
            end
        end else begin
            if (ram_we) ram[ram_addr] <= ram_data;
            if (ram_we2) ram2[ram_addr2] <= ram_data2;
        end
        if (ram_we) we_cnt <= we_cnt + 1;
        if (rx_clr_rdy) clr_cnt <= clr_cnt + 1;
        if (ram_we2) we2_cnt <= we2_cnt + 1;
        if (rx_clr_rdy2) clr2_cnt <= clr2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_restart();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    function automatic logic [7:0] ram_byte(input int base);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ram[base + i];
        return b;
    endfunction

    task automatic check_outs_zero(input string tag);
        check({tag, "_we"}, 32'(ram_we), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_addr"}, 32'(ram_addr), 32'd0);
        check({tag, "_data"}, 32'(ram_data), 32'd0);
        check({tag, "_clr"}, 32'(rx_clr_rdy), 32'd0);
        check({tag, "_done"}, 32'(load_done), 32'd0);
    endtask

    logic [7:0] img [0:97];

    initial begin
        int base_we, base_clr, w_cyc, d_cyc, mism;
        rst = 1'b1;
        restart = 1'b0;
        for (int i = 0; i < 1024; i++) img_init[i] = 1'($urandom);
        init_ram = 1'b1;
        tick();
        tick();
        init_ram = 1'b0;
        check_outs_zero("in_reset");
        @(negedge clk);
        rst = 1'b0;
        negs(1);
        check_outs_zero("after_reset");

        // two directed bytes
        base_we = we_cnt;
        base_clr = clr_cnt;
        tick();
        rxq.push_back(8'hA5);
        rxq.push_back(8'h3C);
        negs(2);
        check("first_clr", 32'(rx_clr_rdy), 32'd1);
        check("first_we", 32'(ram_we), 32'd1);
        check("first_addr", 32'(ram_addr), 32'd0);
        check("first_data", 32'(ram_data), 32'd1);
        negs(30);
        check("byte_a5", 32'(ram_byte(0)), 32'hA5);
        check("byte_3c", 32'(ram_byte(8)), 32'h3C);
        check("two_clr", 32'(clr_cnt - base_clr), 32'd2);
        check("two_we", 32'(we_cnt - base_we), 32'd16);
        check("two_addr", 32'(ram_addr), 32'd16);

        // full random image, bytes back to back
        pulse_restart();
        for (int i = 0; i < 98; i++) begin
            img[i] = 8'($urandom);
            rxq.push_back(img[i]);
        end
        w_cyc = -100;
        d_cyc = -1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (ram_we && ram_addr == 10'd783) w_cyc = cyc;
            if (load_done) begin
                d_cyc = cyc;
                break;
            end
        end
        check("done_latency", 32'(d_cyc - w_cyc), 32'd1);
        check("done_addr", 32'(ram_addr), 32'd783);
        mism = 0;
        for (int i = 0; i < 784; i++)
            if (ram[i] !== img[i / 8][i % 8]) mism++;
        check("image_bits", 32'(mism), 32'd0);
        mism = 0;
        for (int i = 784; i < 1024; i++)
            if (ram[i] !== img_init[i]) mism++;
        check("upper_untouched", 32'(mism), 32'd0);

        // extra byte after DONE stays pending
        base_we = we_cnt;
        base_clr = clr_cnt;
        tick();
        rxq.push_back(8'hFF);
        negs(12);
        check("done_no_clr", 32'(clr_cnt - base_clr), 32'd0);
        check("done_no_we", 32'(we_cnt - base_we), 32'd0);
        check("done_held", 32'(load_done), 32'd1);
        check("done_rdy_pending", 32'(rx_rdy), 32'd1);
        pulse_restart();
        negs(12);
        check("rearm_byte", 32'(ram_byte(0)), 32'hFF);
        check("rearm_done", 32'(load_done), 32'd0);
        check("rearm_addr", 32'(ram_addr), 32'd8);

        // restart during the 4th bit
        pulse_restart();
        base_we = we_cnt;
        tick();
        rxq.push_back(8'h0F);
        negs(5);
        check("abort_addr3", 32'(ram_addr), 32'd3);
        restart = 1'b1;
        negs(1);
        restart = 1'b0;
        check("abort_we", 32'(ram_we), 32'd0);
        check("abort_addr", 32'(ram_addr), 32'd0);
        negs(3);
        check("abort_we_cnt", 32'(we_cnt - base_we), 32'd4);
        tick();
        rxq.push_back(8'hF0);
        negs(12);
        check("byte_f0", 32'(ram_byte(0)), 32'hF0);

        // restart and rx_rdy in the same WAIT_BYTE cycle
        tick();
        rxq.push_back(8'h5A);
        negs(1);
        restart = 1'b1;
        negs(1);
        restart = 1'b0;
        check("same_no_clr", 32'(rx_clr_rdy), 32'd0);
        check("same_busy", 32'(busy), 32'd0);
        check("same_addr", 32'(ram_addr), 32'd0);
        negs(1);
        check("same_clr_next", 32'(rx_clr_rdy), 32'd1);
        check("same_data", 32'(ram_data), 32'd0);
        negs(10);
        check("byte_5a", 32'(ram_byte(0)), 32'h5A);

        // asynchronous reset mid-byte
        tick();
        rxq.push_back(8'hC3);
        negs(4);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_outs_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        tick();
        rxq.push_back(8'h96);
        negs(2);
        check("post_rst_addr", 32'(ram_addr), 32'd0);
        check("post_rst_clr", 32'(rx_clr_rdy), 32'd1);
        negs(10);
        check("byte_96", 32'(ram_byte(0)), 32'h96);

        // 12-bit instance
        base_we = we2_cnt;
        base_clr = clr2_cnt;
        tick();
        rxq2.push_back(8'hFF);
        rxq2.push_back(8'hFF);
        negs(30);
        check("n12_we", 32'(we2_cnt - base_we), 32'd12);
        check("n12_clr", 32'(clr2_cnt - base_clr), 32'd2);
        check("n12_done", 32'(load_done2), 32'd1);
        check("n12_addr", 32'(ram_addr2), 32'd11);
        mism = 0;
        for (int i = 0; i < 12; i++) if (ram2[i] !== 1'b1) mism++;
        for (int i = 12; i < 16; i++) if (ram2[i] !== 1'b0) mism++;
        check("n12_bits", 32'(mism), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
